// File: rtl/flopenr_pkg.sv
// Shared constants for the flopenr enable flop: default data width and the legal width range.
// Imported by the interface, the parity reducer and the top-level flop.
package flopenr_pkg;

  localparam int unsigned FLOPENR_DEFAULT_WIDTH = 32;
  localparam int unsigned FLOPENR_MIN_WIDTH     = 1;
  localparam int unsigned FLOPENR_MAX_WIDTH     = 1024;

  // Elaboration-time guard: true when a requested data width is supported.
  function automatic bit flopenr_width_ok(input int unsigned width);
    return (width >= FLOPENR_MIN_WIDTH) && (width <= FLOPENR_MAX_WIDTH);
  endfunction

endpackage : flopenr_pkg

// File: rtl/flopenr_if.sv
// Bundle of the load-enable / data / result signals around one flopenr instance.
// The q_par member and its modport entries exist only when FLOPENR_PARITY_EN is defined.
interface flopenr_if
  import flopenr_pkg::*;
#(
  parameter int unsigned WIDTH = FLOPENR_DEFAULT_WIDTH
);

  logic             en;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
`ifdef FLOPENR_PARITY_EN
  logic             q_par;

  modport master (output en, output d, input  q, input  q_par);
  modport slave  (input  en, input  d, output q, output q_par);
`else
  modport master (output en, output d, input  q);
  modport slave  (input  en, input  d, output q);
`endif

endinterface : flopenr_if

// File: rtl/flopenr_parity.sv
// Purely combinational even-parity reducer: par is the XOR of every data bit.
// Instantiated by flopenr only when FLOPENR_PARITY_EN is defined.
module flopenr_parity
  import flopenr_pkg::*;
#(
  parameter int unsigned WIDTH = FLOPENR_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  output logic             par
);

  // Reduce the whole word to a single even-parity bit.
  always_comb begin
    par = ^data;
  end

endmodule : flopenr_parity

// File: rtl/flopenr.sv
// Load-enable register with synchronous active-high reset to RESET_VAL.
// Optional registered even-parity output q_par when FLOPENR_PARITY_EN is defined.
module flopenr
  import flopenr_pkg::*;
#(
  parameter int unsigned      WIDTH     = FLOPENR_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
`ifdef FLOPENR_PARITY_EN
  ,
  output logic             q_par
`endif
);

  generate
    if (!flopenr_width_ok(WIDTH)) begin : g_width_check
      $error("flopenr: WIDTH %0d outside supported range", WIDTH);
    end
  endgenerate

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

`ifdef FLOPENR_PARITY_EN
  // Parity of the reset word is fixed at elaboration, so reset needs no reducer.
  localparam logic RESET_PAR = ^RESET_VAL;

  logic par_d;
  logic par_q;

  flopenr_parity #(
    .WIDTH (WIDTH)
  ) u_parity (
    .data (data_d),
    .par  (par_d)
  );
`endif

  // Data path is a straight wire: no transformation between d and the flop.
  always_comb begin
    data_d = d;
  end

  // Storage: reset wins, then load on enable, otherwise hold (data and parity together).
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= RESET_VAL;
`ifdef FLOPENR_PARITY_EN
      par_q  <= RESET_PAR;
`endif
    end else if (en) begin
      data_q <= data_d;
`ifdef FLOPENR_PARITY_EN
      par_q  <= par_d;
`endif
    end else begin
      data_q <= data_q;
`ifdef FLOPENR_PARITY_EN
      par_q  <= par_q;
`endif
    end
  end

  // Outputs come straight from the flops.
  always_comb begin
    q = data_q;
`ifdef FLOPENR_PARITY_EN
    q_par = par_q;
`endif
  end

endmodule : flopenr

// File: tb/tb_flopenr.sv
// Self-checking bench for flopenr at WIDTH=32 (default reset), WIDTH=8 (reset 0xA5) and WIDTH=1 (reset 1).
// Parity outputs are checked when FLOPENR_PARITY_EN is defined.
module tb_flopenr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0;
  logic       en    = 1'b0;
  logic [7:0] d8    = 8'h00;
  logic [7:0] q8;
  logic       d1    = 1'b0;
  logic       q1;
`ifdef FLOPENR_PARITY_EN
  logic       q_par8;
  logic       q_par1;
`endif

  flopenr_if #(.WIDTH(32)) bus32 ();

  flopenr #(.WIDTH(32)) dut32 (
    .clk   (clk),
    .reset (reset),
    .en    (bus32.en),
    .d     (bus32.d),
    .q     (bus32.q)
`ifdef FLOPENR_PARITY_EN
    ,
    .q_par (bus32.q_par)
`endif
  );

  flopenr #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .d     (d8),
    .q     (q8)
`ifdef FLOPENR_PARITY_EN
    ,
    .q_par (q_par8)
`endif
  );

  flopenr #(.WIDTH(1), .RESET_VAL(1'b1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .d     (d1),
    .q     (q1)
`ifdef FLOPENR_PARITY_EN
    ,
    .q_par (q_par1)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference: the word each register should hold after the latest edge.
  logic [31:0] m32;
  logic [7:0]  m8;
  logic        m1;

  // Drive one cycle of inputs, let an edge pass, apply the spec rules to the model, return at negedge.
  task automatic apply(input logic r, input logic e, input logic [31:0] v32,
                       input logic [7:0] v8, input logic v1);
    reset    = r;
    en       = e;
    bus32.en = e;
    bus32.d  = v32;
    d8       = v8;
    d1       = v1;
    @(posedge clk);
    if (r) begin
      m32 = 32'h0000_0000;
      m8  = 8'hA5;
      m1  = 1'b1;
    end else if (e) begin
      m32 = v32;
      m8  = v8;
      m1  = v1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b0, 32'h0000_0000, 8'h00, 1'b0);
    vectors++;
    if (bus32.q !== 32'h0000_0000) begin miscompares++; $display("FAIL reset_q32 got %h want %h", bus32.q, 32'h0); end
    vectors++;
    if (q8 !== 8'hA5) begin miscompares++; $display("FAIL reset_q8 got %h want a5", q8); end
    vectors++;
    if (q1 !== 1'b1) begin miscompares++; $display("FAIL reset_q1 got %b want 1", q1); end
`ifdef FLOPENR_PARITY_EN
    vectors++;
    if (bus32.q_par !== 1'b0) begin miscompares++; $display("FAIL reset_par32 got %b want 0", bus32.q_par); end
    vectors++;
    if (q_par8 !== 1'b0) begin miscompares++; $display("FAIL reset_par8 got %b want 0", q_par8); end
    vectors++;
    if (q_par1 !== 1'b1) begin miscompares++; $display("FAIL reset_par1 got %b want 1", q_par1); end
`endif
    // Reset held across edges with en=1 and moving data keeps the reset value.
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b1, $urandom, 8'($urandom), 1'($urandom));
      vectors++;
      if (bus32.q !== 32'h0 || q8 !== 8'hA5 || q1 !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_hold got %h/%h/%b want 00000000/a5/1", bus32.q, q8, q1);
      end
    end
  endtask

  task automatic test_hold_and_load();
    apply(1'b0, 1'b0, 32'hDEAD_BEEF, 8'h3C, 1'b0);
    vectors++;
    if (bus32.q !== 32'h0000_0000) begin miscompares++; $display("FAIL hold_after_reset got %h want 00000000", bus32.q); end
    vectors++;
    if (q8 !== 8'hA5 || q1 !== 1'b1) begin miscompares++; $display("FAIL hold_small got %h/%b want a5/1", q8, q1); end
    apply(1'b0, 1'b1, 32'hDEAD_BEEF, 8'h3C, 1'b0);
    vectors++;
    if (bus32.q !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL load_deadbeef got %h want deadbeef", bus32.q); end
    vectors++;
    if (q8 !== 8'h3C || q1 !== 1'b0) begin miscompares++; $display("FAIL load_small got %h/%b want 3c/0", q8, q1); end
`ifdef FLOPENR_PARITY_EN
    vectors++;
    if (bus32.q_par !== 1'b0) begin miscompares++; $display("FAIL par_deadbeef got %b want 0", bus32.q_par); end
`endif
    apply(1'b0, 1'b1, 32'hCAFE_BABE, 8'h81, 1'b1);
    vectors++;
    if (bus32.q !== 32'hCAFE_BABE) begin miscompares++; $display("FAIL load_cafebabe got %h want cafebabe", bus32.q); end
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 1'b0, 32'h1234_5678, 8'h7E, 1'b0);
      vectors++;
      if (bus32.q !== 32'hCAFE_BABE || q8 !== 8'h81 || q1 !== 1'b1) begin
        miscompares++;
        $display("FAIL hold_cafebabe got %h/%h/%b want cafebabe/81/1", bus32.q, q8, q1);
      end
    end
  endtask

  task automatic test_reset_priority();
    apply(1'b1, 1'b1, 32'h1234_5678, 8'h5A, 1'b0);
    vectors++;
    if (bus32.q !== 32'h0000_0000 || q8 !== 8'hA5 || q1 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_over_en got %h/%h/%b want 00000000/a5/1", bus32.q, q8, q1);
    end
    apply(1'b0, 1'b1, 32'h1234_5678, 8'h5A, 1'b0);
    vectors++;
    if (bus32.q !== 32'h1234_5678 || q8 !== 8'h5A || q1 !== 1'b0) begin
      miscompares++;
      $display("FAIL load_after_release got %h/%h/%b want 12345678/5a/0", bus32.q, q8, q1);
    end
`ifdef FLOPENR_PARITY_EN
    vectors++;
    if (bus32.q_par !== 1'b1) begin miscompares++; $display("FAIL par_12345678 got %b want 1", bus32.q_par); end
`endif
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      logic [31:0] v32;
      logic [7:0]  v8;
      logic        v1;
      v32 = $urandom;
      v8  = 8'($urandom);
      v1  = 1'($urandom);
      apply(1'b0, 1'b1, v32, v8, v1);
      vectors++;
      if (bus32.q !== v32 || q8 !== v8 || q1 !== v1) begin
        miscompares++;
        $display("FAIL back_to_back[%0d] got %h/%h/%b want %h/%h/%b", i, bus32.q, q8, q1, v32, v8, v1);
      end
    end
  endtask

  task automatic test_between_edges();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] s32;
      logic [7:0]  s8;
      logic        s1;
      s32 = bus32.q;
      s8  = q8;
      s1  = q1;
      for (int k = 0; k < 3; k++) begin
        #1;
        reset    = 1'($urandom);
        en       = 1'($urandom);
        bus32.en = en;
        bus32.d  = $urandom;
        d8       = 8'($urandom);
        d1       = 1'($urandom);
      end
      #0.5;
      vectors++;
      if (bus32.q !== m32 || q8 !== m8 || q1 !== m1 || bus32.q !== s32 || q8 !== s8 || q1 !== s1) begin
        miscompares++;
        $display("FAIL mid_cycle_stable[%0d] got %h/%h/%b want %h/%h/%b", i, bus32.q, q8, q1, m32, m8, m1);
      end
      apply(1'b0, 1'($urandom), $urandom, 8'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      apply(($urandom_range(0, 7) == 0), 1'($urandom), $urandom, 8'($urandom), 1'($urandom));
      vectors++;
      if (bus32.q !== m32 || q8 !== m8 || q1 !== m1) begin
        miscompares++;
        $display("FAIL random[%0d] got %h/%h/%b want %h/%h/%b", i, bus32.q, q8, q1, m32, m8, m1);
      end
`ifdef FLOPENR_PARITY_EN
      vectors++;
      if (bus32.q_par !== ^m32 || q_par8 !== ^m8 || q_par1 !== m1) begin
        miscompares++;
        $display("FAIL random_par[%0d] got %b/%b/%b want %b/%b/%b", i, bus32.q_par, q_par8, q_par1, ^m32, ^m8, m1);
      end
`endif
    end
  endtask

  initial begin
    bus32.en = 1'b0;
    bus32.d  = 32'h0000_0000;
    @(negedge clk);
    test_reset();
    test_hold_and_load();
    test_reset_priority();
    test_back_to_back();
    test_between_edges();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_flopenr

// File: doc/flopenr.md
FLOPENR -- requirements
Module: flopenr

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits, legal range 1..1024.
REQ-002 Parameter RESET_VAL, default all-zeros, WIDTH bits: value loaded into q on reset.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port en  input  1  load enable; active-high.
REQ-006 Port d  input  WIDTH  data to be captured.
REQ-007 Port q  output  WIDTH  registered data.
REQ-008 Port q_par  output  1  registered even-parity bit of q; present only when FLOPENR_PARITY_EN is defined.
REQ-009 The block has one clock; reset is synchronous and active-high.

Function
REQ-010 At a rising clk edge with reset=1, q SHALL become RESET_VAL, regardless of en and d.
REQ-011 At a rising clk edge with reset=0 and en=1, q SHALL become the value of d sampled at that edge; load latency is one cycle.
REQ-012 At a rising clk edge with reset=0 and en=0, q SHALL hold its previous value; changes on d are ignored.
REQ-013 Between clk edges, q SHALL NOT change, including when reset, en or d toggle.
REQ-014 Simultaneous reset=1 and en=1: reset has priority and q becomes RESET_VAL.
REQ-015 Reset asserted while en=1 and d is changing: q becomes RESET_VAL at the first edge that samples reset=1; loading resumes at the first edge with reset=0.
REQ-016 Consecutive edges with en=1 SHALL load each new d; no bubble cycles.
REQ-017 The path from d to q SHALL contain no arithmetic or transformation; all WIDTH bits are loaded together.
REQ-018 Before the first reset edge, q is undefined and is not checked.

Reset
REQ-019 Reset is synchronous only; no asynchronous set or clear path is present.
REQ-020 After reset: q = RESET_VAL; q_par (when present) = XOR-reduction of RESET_VAL.
REQ-021 Holding reset=1 across multiple edges keeps q at RESET_VAL.

Configuration
REQ-022 Macro FLOPENR_PARITY_EN SHALL control the parity feature.
REQ-023 With FLOPENR_PARITY_EN defined: q_par exists and is updated under the same reset, enable and hold rules as q; q_par equals the XOR-reduction of the value in q at all times.
REQ-024 With FLOPENR_PARITY_EN undefined: the q_par port and its logic are absent; q behaviour is identical to the configuration with the macro defined.

Structure
REQ-025 Shared package flopenr_pkg SHALL hold the constant FLOPENR_DEFAULT_WIDTH = 32 and a WIDTH-range check constant; flopenr SHALL import it.
REQ-026 One sub-module, flopenr_parity, is natural: a combinational XOR-reduction of WIDTH bits, instantiated only under FLOPENR_PARITY_EN.
REQ-027 The storage element SHALL be a single clocked process with the priority order reset, then en, then hold.

Verification
REQ-028 reset=1 for 1 edge, en=0, d=0x00000000 -> q=0x00000000; q_par=0.
REQ-029 reset=0, en=0, d=0xDEADBEEF for 1 edge -> q stays 0x00000000.
REQ-030 en=1, d=0xDEADBEEF for 1 edge -> q=0xDEADBEEF; q_par=0.
REQ-031 en=1, d=0xCAFEBABE for 1 edge -> q=0xCAFEBABE; then en=0, d=0x12345678 for 2 edges -> q holds 0xCAFEBABE.
REQ-032 en=1, d=0x12345678, reset=1 on the same edge -> q=0x00000000; release reset -> q=0x12345678 next edge, q_par=1.
REQ-033 WIDTH=1 and WIDTH=8 with RESET_VAL=0xA5 -> reset yields 0xA5; enable and hold rules as above, checked with and without FLOPENR_PARITY_EN.
